// File: rtl/maze_gen.sv
// ============================================================================
// Module   : maze_gen
// Purpose  : Builds the 20x20 maze bitmap (1 = wall, 0 = floor) by a
//            binary-tree carve over a 9x9 cell lattice, driven by a 16-bit
//            Galois LFSR. One tile write per frame_clk, so the build animates.
// Ports    : frame_clk  - clock (vsync-rate frame tick)
//            Reset      - synchronous, active-high
//            start      - one-cycle request to build a new maze
//            seed_load  - load LFSR from seed this cycle (0 -> SEED_DEFAULT)
//            seed       - LFSR seed value
//            outmaze    - [0:19] rows, outmaze[row][col], bit index = column
//            busy       - high while FILL/CARVE
//            done       - one-cycle pulse when a build completes
//            maze_valid - high from completion until next start/Reset
// Options  : MAZE_LOOPS_EN - when defined, interior cells whose lfsr[3:1] is
//            zero open both north and west passages (maze gains loops).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_gen #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS    = 16'hB400
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [19:0] outmaze [0:19],
  output logic        busy,
  output logic        done,
  output logic        maze_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CARVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  row_ctr_q, row_ctr_d;
  logic [3:0]  cell_i_q, cell_i_d;
  logic [3:0]  cell_j_q, cell_j_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [19:0] maze_q [0:19];
  logic [19:0] maze_d [0:19];

  // Tile coordinates of the current cell: r = 2 + 2i, c = 2 + 2j.
  logic [4:0] tile_r;
  logic [4:0] tile_c;
  logic       go_north;
  logic       go_west;

  assign tile_r = {cell_i_q, 1'b0} + 5'd2;
  assign tile_c = {cell_j_q, 1'b0} + 5'd2;

  // Passage choice uses the LFSR value held this cycle (before it advances).
  // Top row can only go west, left column can only go north, spawn cell none.
  always_comb begin
    go_north = 1'b0;
    go_west  = 1'b0;
    if (cell_i_q == 4'd0) begin
      go_west = (cell_j_q != 4'd0);
    end else if (cell_j_q == 4'd0) begin
      go_north = 1'b1;
    end else begin
`ifdef MAZE_LOOPS_EN
      if (lfsr_q[3:1] == 3'b000) begin
        go_north = 1'b1;
        go_west  = 1'b1;
      end else if (lfsr_q[0]) begin
        go_north = 1'b1;
      end else begin
        go_west = 1'b1;
      end
`else
      if (lfsr_q[0]) begin
        go_north = 1'b1;
      end else begin
        go_west = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    // LFSR free-runs in every state; a seed load takes precedence.
    if (seed_load) begin
      lfsr_d = (seed == 16'h0000) ? SEED_DEFAULT : seed;
    end else begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    state_d   = state_q;
    row_ctr_d = row_ctr_q;
    cell_i_d  = cell_i_q;
    cell_j_d  = cell_j_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    maze_d    = maze_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FILL;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          row_ctr_d = 5'd0;
        end
      end
      ST_FILL: begin
        maze_d[row_ctr_q] = 20'hFFFFF;
        if (row_ctr_q == 5'd19) begin
          state_d  = ST_CARVE;
          cell_i_d = 4'd0;
          cell_j_d = 4'd0;
        end else begin
          row_ctr_d = row_ctr_q + 5'd1;
        end
      end
      ST_CARVE: begin
        maze_d[tile_r][tile_c] = 1'b0;
        if (go_north) maze_d[tile_r - 5'd1][tile_c] = 1'b0;
        if (go_west)  maze_d[tile_r][tile_c - 5'd1] = 1'b0;
        if (cell_j_q == 4'd8) begin
          cell_j_d = 4'd0;
          if (cell_i_q == 4'd8) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            cell_i_d = cell_i_q + 4'd1;
          end
        end else begin
          cell_j_d = cell_j_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED_DEFAULT;
      row_ctr_q <= 5'd0;
      cell_i_q  <= 4'd0;
      cell_j_q  <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      for (int k = 0; k < 20; k++) maze_q[k] <= 20'hFFFFF;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      row_ctr_q <= row_ctr_d;
      cell_i_q  <= cell_i_d;
      cell_j_q  <= cell_j_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      maze_q    <= maze_d;
    end
  end

  assign outmaze    = maze_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign maze_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_gen.sv
// ============================================================================
// Module   : tb_maze_gen
// Purpose  : Scoreboard bench for maze_gen. Each build request pushes the
//            reference maze into a queue; a monitor pops and compares on done,
//            and also checks build length, pulse shape, stability and the
//            maze shape rules (walls, cell count, reachability).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_gen;

  logic        frame_clk;
  logic        Reset;
  logic        start;
  logic        seed_load;
  logic [15:0] seed;
  logic [19:0] outmaze [0:19];
  logic        busy;
  logic        done;
  logic        maze_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [399:0] sb [$];

  maze_gen dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .start      (start),
    .seed_load  (seed_load),
    .seed       (seed),
    .outmaze    (outmaze),
    .busy       (busy),
    .done       (done),
    .maze_valid (maze_valid)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Reference: spec-level maze construction. LFSR value seen by cell n is
  // the loaded seed stepped 20 (fill) + n times.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [399:0] model_maze(input logic [15:0] s);
    logic [399:0] m;
    logic [15:0]  l;
    int r, c;
    m = '1;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < 20; k++) l = lfsr_step(l);
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) begin
        r = 2 + 2 * i;
        c = 2 + 2 * j;
        m[r * 20 + c] = 1'b0;
        if (i == 0 && j > 0) m[r * 20 + c - 1] = 1'b0;
        else if (i > 0 && j == 0) m[(r - 1) * 20 + c] = 1'b0;
        else if (i > 0 && j > 0) begin
`ifdef MAZE_LOOPS_EN
          if (l[3:1] == 3'b000) begin
            m[(r - 1) * 20 + c] = 1'b0;
            m[r * 20 + c - 1]   = 1'b0;
          end else
`endif
          if (l[0]) m[(r - 1) * 20 + c] = 1'b0;
          else      m[r * 20 + c - 1]   = 1'b0;
        end
        l = lfsr_step(l);
      end
    end
    return m;
  endfunction

  function automatic logic [399:0] pack_maze();
    logic [399:0] v;
    for (int r = 0; r < 20; r++) v[r * 20 +: 20] = outmaze[r];
    return v;
  endfunction

  // Returns number of failed shape checks (3 checks per call).
  function automatic int check_shape(input logic [399:0] mz);
    int  fails = 0;
    int  zeros = 0;
    int  bad_walls = 0;
    int  reached = 0;
    int  iter = 0;
    bit  vis [20][20];
    bit  changed;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 20; c++) begin
        vis[r][c] = 1'b0;
        if (mz[r * 20 + c] == 1'b0) zeros++;
        if ((r < 2 || r == 19 || c < 2 || c == 19 || (r % 2 == 1 && c % 2 == 1))
            && mz[r * 20 + c] != 1'b1) bad_walls++;
      end
    end
    if (mz[2 * 20 + 2] == 1'b0) vis[2][2] = 1'b1;
    changed = 1'b1;
    while (changed && iter < 400) begin
      changed = 1'b0;
      iter++;
      for (int r = 1; r < 19; r++) begin
        for (int c = 1; c < 19; c++) begin
          if (!vis[r][c] && mz[r * 20 + c] == 1'b0 &&
              (vis[r-1][c] || vis[r+1][c] || vis[r][c-1] || vis[r][c+1])) begin
            vis[r][c] = 1'b1;
            changed = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        if (vis[2 + 2 * i][2 + 2 * j]) reached++;
    if (bad_walls != 0) begin
      fails++;
      $display("FAIL shape_walls: %0d fixed-wall tiles open, required 0", bad_walls);
    end
`ifdef MAZE_LOOPS_EN
    if (zeros < 161) begin
      fails++;
      $display("FAIL shape_zero_count: got %0d, required >= 161", zeros);
    end
`else
    if (zeros != 161) begin
      fails++;
      $display("FAIL shape_zero_count: got %0d, required 161", zeros);
    end
`endif
    if (reached != 81) begin
      fails++;
      $display("FAIL shape_reach: %0d cells reachable from (2,2), required 81", reached);
    end
    return fails;
  endfunction

  // Monitor: compares on done, tracks build length and post-build stability.
  logic [399:0] snap;
  bit           snap_valid = 1'b0;
  bit           prev_done  = 1'b0;
  int           busy_cnt   = 0;

  initial begin
    logic [399:0] got;
    logic [399:0] exp;
    int           f;
    forever begin
      @(negedge frame_clk);
      got = pack_maze();
      if (Reset === 1'b1) begin
        busy_cnt   = 0;
        snap_valid = 1'b0;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
          tests_run++;
          if (prev_done) begin
            tests_failed++;
            $display("FAIL done_pulse: done high 2 cycles, required 1");
          end
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_done: done with no pending build");
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              tests_failed++;
              for (int r = 0; r < 20; r++) begin
                if (got[r * 20 +: 20] !== exp[r * 20 +: 20]) begin
                  $display("FAIL maze_match: row %0d got %05h required %05h",
                           r, got[r * 20 +: 20], exp[r * 20 +: 20]);
                  break;
                end
              end
            end
          end
          tests_run++;
          if (busy_cnt != 101) begin
            tests_failed++;
            $display("FAIL busy_length: got %0d cycles, required 101", busy_cnt);
          end
          tests_run++;
          if ({busy, maze_valid} !== 2'b01) begin
            tests_failed++;
            $display("FAIL done_flags: busy,maze_valid got %b required 01", {busy, maze_valid});
          end
          tests_run += 3;
          f = check_shape(got);
          tests_failed += f;
          busy_cnt   = 0;
          snap       = got;
          snap_valid = 1'b1;
        end else if (maze_valid === 1'b1 && snap_valid) begin
          tests_run++;
          if (got !== snap) begin
            tests_failed++;
            $display("FAIL maze_stable: outmaze changed while maze_valid=1");
            snap = got;
          end
        end
        if (maze_valid !== 1'b1) snap_valid = 1'b0;
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic check_reset_state(input string tag);
    bit rows_ok = 1'b1;
    for (int r = 0; r < 20; r++) if (outmaze[r] !== 20'hFFFFF) rows_ok = 1'b0;
    tests_run++;
    if (!rows_ok) begin
      tests_failed++;
      $display("FAIL %s_rows: some outmaze row not 20'hFFFFF (row0=%05h)", tag, outmaze[0]);
    end
    tests_run++;
    if ({busy, done, maze_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s_flags: busy,done,maze_valid got %b required 000", tag,
               {busy, done, maze_valid});
    end
  endtask

  // One build: start+seed_load together. Optional second start at restart_at,
  // optional Reset at reset_at (aborts, so no expectation is queued).
  task automatic run_build(input logic [15:0] s, input int restart_at, input int reset_at);
    bit finished = 1'b0;
    @(posedge frame_clk); #1;
    start     = 1'b1;
    seed_load = 1'b1;
    seed      = s;
    if (reset_at < 0) sb.push_back(model_maze(s));
    @(posedge frame_clk); #1;
    start     = 1'b0;
    seed_load = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == reset_at) begin
        Reset = 1'b1;
        @(posedge frame_clk); #1;
        Reset = 1'b0;
        check_reset_state("midbuild_reset");
        return;
      end
      start = (k == restart_at);
      @(posedge frame_clk); #1;
      if (maze_valid === 1'b1) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    tests_run++;
    if (!finished) begin
      tests_failed++;
      $display("FAIL build_timeout: maze_valid not seen within 300 cycles, seed %04h", s);
    end
    repeat (3) @(posedge frame_clk);
    #1;
  endtask

  initial begin
    Reset     = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0000;
    repeat (2) @(posedge frame_clk);
    #1;
    check_reset_state("reset");
    Reset = 1'b0;

    run_build(16'h0001, -1, -1);
    run_build(16'hBEEF, -1, -1);
    run_build(16'h0000, -1, -1);
    run_build(16'hACE1, -1, -1);
    run_build(16'h0001, 50, -1);
    run_build(16'h0001, -1, 40);
    run_build(16'h0001, -1, -1);
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 5)) @(posedge frame_clk);
      run_build(16'($urandom), -1, -1);
    end

    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_builds: %0d expected builds never completed", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
